prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set instruction/data memory address width.
REQ-002 Parameter WORD_SIZE, default gc::WORD_SIZE, SHALL set memory word width and SHALL be a multiple of 8.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  serial program byte valid.
REQ-006 in_data  input  8  program byte.
REQ-007 in_ready  output  1  byte accepted when in_valid and in_ready are both high at a clock edge.
REQ-008 reload  input  1  single-cycle request to restart loading from DONE or ERR.
REQ-009 mem_we  output  1  one-cycle memory write strobe to the processor memory.
REQ-010 mem_addr  output  ADDR_W  write address.
REQ-011 mem_wdata  output  WORD_SIZE  write data.
REQ-012 core_rst  output  1  active-high reset driven to the top-level processor's rst.
REQ-013 done  output  1  program loaded and checksum verified.
REQ-014 err  output  1  load failed.

Function
REQ-015 Byte stream format SHALL be: count word N, then N data words, then checksum word; each word SHALL be WORD_SIZE/8 bytes, little-endian (first byte = bits 7:0).
REQ-016 FSM states SHALL be HDR, LOAD, CSUM, DONE, ERR; reset state HDR.
REQ-017 in_ready SHALL be high in HDR, LOAD, CSUM and low in DONE, ERR.
REQ-018 A byte counter SHALL assemble words; it SHALL wrap to 0 after the last byte of each word.
REQ-019 HDR: on completed word, N=0 SHALL go to CSUM, N>2^ADDR_W SHALL go to ERR, otherwise LOAD.
REQ-020 LOAD: each completed word SHALL produce mem_we=1 for exactly one cycle, in the cycle after the final byte's acceptance edge, with mem_addr = word index (starting at 0) and mem_wdata = assembled word.
REQ-021 LOAD SHALL transition to CSUM after the Nth word's final byte; the address counter SHALL NOT wrap within a load.
REQ-022 Running checksum SHALL be the sum, modulo 2^WORD_SIZE, of the count word and all data words.
REQ-023 CSUM: on completed word, match SHALL go to DONE, mismatch SHALL go to ERR.
REQ-024 core_rst SHALL be 1 in every state except DONE; it SHALL fall on the first edge after entering DONE.
REQ-025 done SHALL be 1 only in DONE; err SHALL be 1 only in ERR; both registered.
REQ-026 reload in DONE or ERR SHALL clear counters and checksum, assert core_rst, and enter HDR next cycle; reload in other states SHALL be ignored.
REQ-027 mem_we SHALL be 0 in HDR, CSUM, DONE, ERR except the LOAD-trailing strobe of REQ-020.
REQ-028 in_valid while in_ready low SHALL have no effect.

Reset
REQ-029 rst low SHALL immediately force state HDR, core_rst=1, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, in_ready=1 after release, counters and checksum 0.
REQ-030 rst asserted mid-load SHALL abandon the partial word; the next accepted byte after release SHALL be treated as byte 0 of a count word.

Structure
REQ-031 Loader state enum and byte-per-word constant SHALL live in package gc beside WORD_SIZE.
REQ-032 Word assembly (byte counter + shift register + word-complete pulse) SHALL be one sub-module named byte_packer; FSM, address counter and checksum in prog_loader.

Verification (values for WORD_SIZE=16, ADDR_W=4)
REQ-033 Bytes 03 00, 11 11, 22 22, 33 33, 69 66 -> three mem_we pulses addr 0/1/2 data 1111/2222/3333, done=1, core_rst falls.
REQ-034 Same stream with checksum 00 00 -> err=1, core_rst stays 1, in_ready=0.
REQ-035 Count 11 00 (17 > 16) -> err=1, no mem_we pulse.
REQ-036 Count 00 00, checksum 00 00 -> done=1 with no mem_we.
REQ-037 rst pulsed low after byte 3 of REQ-033 stream, then full stream resent -> identical result to REQ-033.
REQ-038 From ERR, reload pulse then REQ-033 stream with in_valid toggling randomly -> done=1, same writes.

Source files
------------

// File: rtl/gc_pkg.sv
// Shared loader constants and types: word size, bytes per word, loader state encoding.
package gc;

    localparam int unsigned WORD_SIZE      = 16;
    localparam int unsigned BYTES_PER_WORD = WORD_SIZE / 8;

    typedef enum logic [2:0] {
        HDR,
        LOAD,
        CSUM,
        DONE,
        ERR
    } load_state_e;

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian words from a byte stream and flags the byte that completes each word.
module byte_packer #(
    parameter int unsigned WORD_SIZE = gc::WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 accept,
    input  logic [7:0]           in_data,
    output logic [WORD_SIZE-1:0] word_c,
    output logic                 word_done_c
);

    localparam int unsigned BPW   = WORD_SIZE / 8;
    localparam int unsigned CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CNT_W-1:0]     cnt;
    logic [WORD_SIZE-1:0] shreg;
    logic                 last_c;

    // New byte enters at the top so the first byte ends up in bits 7:0.
    assign word_c      = (shreg >> 8) | (WORD_SIZE'(in_data) << (WORD_SIZE - 8));
    assign last_c      = (cnt == CNT_W'(BPW - 1));
    assign word_done_c = accept && last_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (clr) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (accept) begin
            shreg <= word_c;
            cnt   <= last_c ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Loads a count/data/checksum byte stream into processor memory, holding the core in reset until verified.
module prog_loader
    import gc::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned WORD_SIZE = gc::WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    input  logic                 reload,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic                 core_rst,
    output logic                 done,
    output logic                 err
);

    // Wide enough to hold both a count word and the value 2^ADDR_W.
    localparam int unsigned       CMP_W = (WORD_SIZE > ADDR_W + 1) ? WORD_SIZE : ADDR_W + 1;
    localparam logic [CMP_W-1:0]  MAX_N = CMP_W'(1) << ADDR_W;

    load_state_e          state;
    logic [CMP_W-1:0]     count;
    logic [CMP_W-1:0]     idx;
    logic [WORD_SIZE-1:0] csum;

    logic                 accept_c;
    logic                 clr_c;
    logic [WORD_SIZE-1:0] word_c;
    logic                 word_done_c;
    logic [CMP_W-1:0]     word_ext_c;
    logic [CMP_W-1:0]     idx_next_c;

    assign accept_c   = in_valid && in_ready;
    assign clr_c      = reload && ((state == DONE) || (state == ERR));
    assign word_ext_c = CMP_W'(word_c);
    assign idx_next_c = idx + CMP_W'(1);

    byte_packer #(
        .WORD_SIZE (WORD_SIZE)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr_c),
        .accept      (accept_c),
        .in_data     (in_data),
        .word_c      (word_c),
        .word_done_c (word_done_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HDR;
            count     <= '0;
            idx       <= '0;
            csum      <= '0;
            in_ready  <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            core_rst  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we   <= 1'b0;
            // Released one edge after DONE is entered; re-asserted by the reload edge.
            core_rst <= !((state == DONE) && !reload);
            case (state)
                HDR: begin
                    if (word_done_c) begin
                        count <= word_ext_c;
                        csum  <= word_c;
                        idx   <= '0;
                        if (word_c == '0) begin
                            state <= CSUM;
                        end else if (word_ext_c > MAX_N) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (word_done_c) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= idx[ADDR_W-1:0];
                        mem_wdata <= word_c;
                        csum      <= csum + word_c;
                        idx       <= idx_next_c;
                        if (idx_next_c == count) begin
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (word_done_c) begin
                        in_ready <= 1'b0;
                        if (word_c == csum) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                DONE, ERR: begin
                    if (reload) begin
                        state    <= HDR;
                        in_ready <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        count    <= '0;
                        idx      <= '0;
                        csum     <= '0;
                    end
                end
                default: begin
                    state    <= HDR;
                    in_ready <= 1'b1;
                    done     <= 1'b0;
                    err      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with 16-bit words and a 16-entry memory.
module tb_prog_loader;

    localparam int unsigned AW = 4;
    localparam int unsigned WS = 16;

    typedef logic [7:0] byte_q_t[$];

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          reload;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [WS-1:0] mem_wdata;
    logic          core_rst;
    logic          done;
    logic          err;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] wa[$];
    logic [15:0] wd[$];

    byte_q_t good_s;
    byte_q_t bad_s;
    byte_q_t big_s;
    byte_q_t empty_s;
    byte_q_t part_s;

    prog_loader #(
        .ADDR_W    (AW),
        .WORD_SIZE (WS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .reload    (reload),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_rst  (core_rst),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Record every write strobe seen mid-cycle.
    always @(negedge clk) begin
        if (rst && mem_we) begin
            wa.push_back(16'(mem_addr));
            wd.push_back(16'(mem_wdata));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit took  = 1'b0;
        int guard = 0;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!took && guard < 20) begin
            took = in_ready;
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        if (!took) check("byte_accept", 32'd0, 32'd1);
    endtask

    task automatic send_stream(input byte_q_t s, input bit gaps);
        foreach (s[i]) send_byte(s[i], gaps);
    endtask

    task automatic wait_end();
        int k = 0;
        while (!(done || err) && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
    endtask

    task automatic check_good_writes(input string tag);
        check({tag, "_wr_count"}, 32'(wa.size()), 32'd3);
        for (int i = 0; i < 3 && i < wa.size(); i++) begin
            check({tag, "_wr_addr"}, 32'(wa[i]), 32'(i));
            check({tag, "_wr_data"}, 32'(wd[i]), 32'(16'h1111 * (i + 1)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        good_s  = '{8'h03, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h69, 8'h66};
        bad_s   = '{8'h03, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h00, 8'h00};
        big_s   = '{8'h11, 8'h00};
        empty_s = '{8'h00, 8'h00, 8'h00, 8'h00};
        part_s  = '{8'h03, 8'h00, 8'h11};

        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Good three-word program
        clear_log();
        send_stream(good_s, 1'b0);
        wait_end();
        check("good_done", 32'(done), 32'd1);
        check("good_err", 32'(err), 32'd0);
        check("good_in_ready", 32'(in_ready), 32'd0);
        check_good_writes("good");
        repeat (2) @(negedge clk);
        check("good_core_rst", 32'(core_rst), 32'd0);
        in_valid = 1'b1; in_data = 8'h55;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        check("idle_no_write", 32'(wa.size()), 32'd3);
        check("idle_done", 32'(done), 32'd1);

        // Bad checksum
        pulse_reload();
        check("reload_in_ready", 32'(in_ready), 32'd1);
        check("reload_core_rst", 32'(core_rst), 32'd1);
        check("reload_done", 32'(done), 32'd0);
        clear_log();
        send_stream(bad_s, 1'b0);
        wait_end();
        check("bad_err", 32'(err), 32'd1);
        check("bad_done", 32'(done), 32'd0);
        check("bad_core_rst", 32'(core_rst), 32'd1);
        check("bad_in_ready", 32'(in_ready), 32'd0);
        check("bad_wr_count", 32'(wa.size()), 32'd3);

        // Count too large
        pulse_reload();
        clear_log();
        send_stream(big_s, 1'b0);
        wait_end();
        repeat (2) @(negedge clk);
        check("big_err", 32'(err), 32'd1);
        check("big_wr_count", 32'(wa.size()), 32'd0);
        check("big_core_rst", 32'(core_rst), 32'd1);

        // Empty program
        pulse_reload();
        clear_log();
        send_stream(empty_s, 1'b0);
        wait_end();
        check("empty_done", 32'(done), 32'd1);
        check("empty_wr_count", 32'(wa.size()), 32'd0);
        repeat (2) @(negedge clk);
        check("empty_core_rst", 32'(core_rst), 32'd0);

        // Reset mid-load, then full stream
        pulse_reload();
        send_stream(part_s, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_core_rst", 32'(core_rst), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        clear_log();
        send_stream(good_s, 1'b0);
        wait_end();
        check("midrst_done_end", 32'(done), 32'd1);
        check_good_writes("midrst");

        // From ERR, reload then gapped stream
        pulse_reload();
        send_stream(big_s, 1'b0);
        wait_end();
        check("gap_pre_err", 32'(err), 32'd1);
        pulse_reload();
        clear_log();
        send_stream(good_s, 1'b1);
        wait_end();
        check("gap_done", 32'(done), 32'd1);
        check("gap_err", 32'(err), 32'd0);
        check_good_writes("gap");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
